// File: rtl/cmp_slice_sequencer_if.sv
// Requester handshake plus the shared comparator-slice hookup for cmp_slice_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface cmp_slice_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             err;
  logic [SLICE-1:0] cmp_a;
  logic [SLICE-1:0] cmp_b;
  logic             cmp_l;
  logic             cmp_e;
  logic             cmp_g;
  logic             cmp_L;
  logic             cmp_E;
  logic             cmp_G;

  modport slave (
    input  start, a, b, cmp_L, cmp_E, cmp_G,
    output busy, done, lt, eq, gt, err, cmp_a, cmp_b, cmp_l, cmp_e, cmp_g
  );

  modport master (
    output start, a, b, cmp_L, cmp_E, cmp_G,
    input  busy, done, lt, eq, gt, err, cmp_a, cmp_b, cmp_l, cmp_e, cmp_g
  );
endinterface

// File: rtl/cmp_slice_sequencer.sv
// Runs one shared cascadable comparator slice over WIDTH-bit operands, LSB slice first,
// feeding each slice's L/E/G back as the next slice's cascade input.
module cmp_slice_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmp_slice_sequencer_if.slave  bus_io
);
  localparam int unsigned SliceSafe = (SLICE == 0) ? 1 : SLICE;
  localparam int unsigned NSLICE    = (WIDTH / SliceSafe == 0) ? 1 : WIDTH / SliceSafe;
  localparam int unsigned IdxW      = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  if (SLICE == 0 || WIDTH == 0 || (WIDTH % SliceSafe) != 0) begin : g_param_check
    $error("cmp_slice_sequencer: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       chain_q, chain_d;  // {l, e, g}
  logic             err_acc_q, err_acc_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             slice_bad;

  assign slice_bad = !$onehot({bus_io.cmp_L, bus_io.cmp_E, bus_io.cmp_G});

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    chain_d   = chain_q;
    err_acc_d = err_acc_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d   = StRun;
          a_d       = bus_io.a;
          b_d       = bus_io.b;
          idx_d     = '0;
          chain_d   = 3'b010;
          err_acc_d = 1'b0;
        end
      end
      StRun: begin
        chain_d   = {bus_io.cmp_L, bus_io.cmp_E, bus_io.cmp_G};
        err_acc_d = err_acc_q | slice_bad;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = '0;
          lt_d    = bus_io.cmp_L;
          eq_d    = bus_io.cmp_E;
          gt_d    = bus_io.cmp_G;
          err_d   = err_acc_q | slice_bad;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      chain_q   <= 3'b010;
      err_acc_q <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b1;
      gt_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      chain_q   <= chain_d;
      err_acc_q <= err_acc_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.busy  = (state_q == StRun);
  assign bus_io.done  = done_q;
  assign bus_io.lt    = lt_q;
  assign bus_io.eq    = eq_q;
  assign bus_io.gt    = gt_q;
  assign bus_io.err   = err_q;
  assign bus_io.cmp_a = a_q[idx_q * SLICE +: SLICE];
  assign bus_io.cmp_b = b_q[idx_q * SLICE +: SLICE];
  assign {bus_io.cmp_l, bus_io.cmp_e, bus_io.cmp_g} = chain_q;
endmodule
